// File: rtl/raw_dma_ctrl_regs.sv
// raw_dma_ctrl_regs: DMA control/status register bank with frame-buffer ring sequencer and level irq
module raw_dma_ctrl_regs #(
    parameter int          NUM_BUFS = 4,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] VERSION  = 32'h0001_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        mem_wr_valid,
    input  logic [31:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_addr,
    output logic [31:0] mem_rd_data,
    input  logic        dma_busy,
    input  logic        dma_frame_done,
    input  logic        dma_overflow,
    output logic        dma_start,
    output logic [31:0] dma_buf_addr,
    output logic [31:0] dma_line_bytes,
    output logic [31:0] dma_num_lines,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
    localparam logic [1:0] LAST_IDX = 2'(NUM_BUFS - 1);

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [1:0]  irq_sts_q, irq_sts_d;
    logic [1:0]  buf_idx_q, buf_idx_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] line_bytes_q, num_lines_q;
    logic [31:0] buf_addr_q [4];
    logic [31:0] buf_addr_d [4];
    logic        dma_start_q, dma_start_d;
    logic [31:0] dma_buf_addr_q;
    logic        irq_q;
    logic [31:0] wa, ra;
    logic        wr_ctrl, wr_start, wr_irq, wr_line, wr_lines;
    logic        cont, start_req, evt;
    logic        unused_bits;

    // Word indices; only the low ADDR_W byte-address bits take part in decode
    assign wa = 32'(mem_wr_addr[ADDR_W-1:2]);
    assign ra = 32'(mem_rd_addr[ADDR_W-1:2]);
    assign unused_bits = ^{mem_wr_addr[31:ADDR_W], mem_wr_addr[1:0], mem_rd_addr[31:ADDR_W], mem_rd_addr[1:0]};

    assign wr_ctrl   = mem_wr_valid && wa == 32'd1;
    assign wr_start  = mem_wr_valid && wa == 32'd2;
    assign wr_irq    = mem_wr_valid && wa == 32'd4;
    assign wr_line   = mem_wr_valid && wa == 32'd6;
    assign wr_lines  = mem_wr_valid && wa == 32'd7;
    assign cont      = ctrl_q[0] & ctrl_q[1];
    assign start_req = wr_start & mem_wr_data[0] & ctrl_q[0];
    assign evt       = dma_frame_done & (state_q != IDLE);

    // Frame sequencer state register
    always_ff @(posedge aclk) begin
        if (areset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // Frame sequencer next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_req ? RUN : IDLE;
            RUN:     state_d = dma_frame_done ? (cont ? RUN : IDLE) : ((wr_ctrl && !mem_wr_data[0]) ? STOP : RUN);
            STOP:    state_d = dma_frame_done ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Frame sequencer output: software start from IDLE or back-to-back restart in continuous mode
    always_comb begin
        dma_start_d = (state_q == IDLE && start_req) || (state_q == RUN && dma_frame_done && cont);
    end

    // Next values of the register bank; a status set in the same cycle as its W1C wins
    always_comb begin
        ctrl_d      = wr_ctrl ? mem_wr_data[2:0] : ctrl_q;
        irq_sts_d   = (irq_sts_q & ~(wr_irq ? mem_wr_data[1:0] : 2'b00)) | {dma_overflow, evt};
        frame_cnt_d = frame_cnt_q + 32'(evt);
        buf_idx_d   = evt ? ((buf_idx_q == LAST_IDX) ? 2'd0 : buf_idx_q + 2'd1) : buf_idx_q;
        for (int i = 0; i < 4; i++)
            buf_addr_d[i] = (mem_wr_valid && i < NUM_BUFS && wa == 32'(8 + i)) ? mem_wr_data : buf_addr_q[i];
    end

    // Register bank; the buffer address tracks the next index so it is valid alongside dma_start
    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q         <= '0;
            irq_sts_q      <= '0;
            frame_cnt_q    <= '0;
            buf_idx_q      <= '0;
            line_bytes_q   <= '0;
            num_lines_q    <= '0;
            buf_addr_q     <= '{default: '0};
            dma_start_q    <= 1'b0;
            dma_buf_addr_q <= '0;
            irq_q          <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            irq_sts_q      <= irq_sts_d;
            frame_cnt_q    <= frame_cnt_d;
            buf_idx_q      <= buf_idx_d;
            line_bytes_q   <= wr_line ? mem_wr_data : line_bytes_q;
            num_lines_q    <= wr_lines ? mem_wr_data : num_lines_q;
            buf_addr_q     <= buf_addr_d;
            dma_start_q    <= dma_start_d;
            dma_buf_addr_q <= buf_addr_d[buf_idx_d];
            irq_q          <= ctrl_q[2] & (|irq_sts_q);
        end
    end

    // Zero-latency read mux
    always_comb begin
        case (ra)
            32'd0:   mem_rd_data = VERSION;
            32'd1:   mem_rd_data = {29'd0, ctrl_q};
            32'd3:   mem_rd_data = {26'd0, buf_idx_q, 1'b0, state_q, dma_busy};
            32'd4:   mem_rd_data = {30'd0, irq_sts_q};
            32'd5:   mem_rd_data = frame_cnt_q;
            32'd6:   mem_rd_data = line_bytes_q;
            32'd7:   mem_rd_data = num_lines_q;
            default: mem_rd_data = (ra >= 32'd8 && ra < 32'(8 + NUM_BUFS)) ? buf_addr_q[ra[1:0]] : 32'd0;
        endcase
    end

    assign dma_start      = dma_start_q;
    assign dma_buf_addr   = dma_buf_addr_q;
    assign dma_line_bytes = line_bytes_q;
    assign dma_num_lines  = num_lines_q;
    assign irq            = irq_q;
endmodule

// File: tb/tb_raw_dma_ctrl_regs.sv
// tb_raw_dma_ctrl_regs: directed scenarios plus random traffic against a behavioural register model
module tb_raw_dma_ctrl_regs;
    localparam int NUM_BUFS = 4;

    logic        aclk = 1'b0, areset = 1'b1;
    logic        mem_wr_valid = 1'b0, dma_busy = 1'b0, dma_frame_done = 1'b0, dma_overflow = 1'b0;
    logic [31:0] mem_wr_addr = '0, mem_wr_data = '0, mem_rd_addr = '0;
    logic [31:0] mem_rd_data, dma_buf_addr, dma_line_bytes, dma_num_lines;
    logic        dma_start, irq;

    raw_dma_ctrl_regs #(.NUM_BUFS(NUM_BUFS)) dut (
        .aclk(aclk), .areset(areset),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .dma_busy(dma_busy), .dma_frame_done(dma_frame_done), .dma_overflow(dma_overflow),
        .dma_start(dma_start), .dma_buf_addr(dma_buf_addr),
        .dma_line_bytes(dma_line_bytes), .dma_num_lines(dma_num_lines), .irq(irq)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;

    // Model: state 0 idle, 1 running, 2 stopping
    logic [31:0] m_ctrl, m_cnt, m_line, m_nl, m_sts;
    logic [31:0] m_bufs [4];
    int          m_state, m_idx;
    logic        m_start, m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_ctrl = 0; m_cnt = 0; m_line = 0; m_nl = 0; m_sts = 0;
        m_bufs = '{default: 32'd0};
        m_state = 0; m_idx = 0; m_start = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        int w = int'(a[7:2]);
        case (w)
            0: return 32'h0001_0000;
            1: return m_ctrl;
            3: return {26'd0, 2'(m_idx), 1'b0, 2'(m_state), dma_busy};
            4: return m_sts;
            5: return m_cnt;
            6: return m_line;
            7: return m_nl;
            default: return (w >= 8 && w < 8 + NUM_BUFS) ? m_bufs[w-8] : 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic wv, input logic [7:0] wa, input logic [31:0] wd, input logic fd, input logic ov);
        logic done = fd && m_state != 0;
        logic irq_n = m_ctrl[2] && m_sts != 0;
        m_start = 0;
        if (m_state == 0 && wv && wa == 8'h08 && wd[0] && m_ctrl[0]) begin
            m_state = 1; m_start = 1;
        end else if (done) begin
            m_cnt = m_cnt + 1;
            m_idx = (m_idx + 1) % NUM_BUFS;
            if (m_state == 1 && m_ctrl[0] && m_ctrl[1]) m_start = 1;
            else m_state = 0;
        end else if (m_state == 1 && wv && wa == 8'h04 && !wd[0]) m_state = 2;
        if (wv) begin
            if (wa == 8'h04) m_ctrl = {29'd0, wd[2:0]};
            if (wa == 8'h10) m_sts = m_sts & ~wd;
            if (wa == 8'h18) m_line = wd;
            if (wa == 8'h1C) m_nl = wd;
            for (int i = 0; i < NUM_BUFS; i++) if (wa == 8'(8'h20 + 4 * i)) m_bufs[i] = wd;
        end
        m_sts = m_sts | {30'd0, ov, done};
        m_irq = irq_n;
    endtask

    // One clock with the given inputs, then compare every output and one random read
    task automatic cycle(input logic wv, input logic [7:0] wa, input logic [31:0] wd, input logic fd, input logic ov);
        mem_wr_valid = wv; mem_wr_addr = {24'($urandom), wa}; mem_wr_data = wd;
        dma_frame_done = fd; dma_overflow = ov;
        @(posedge aclk);
        model_step(wv, wa, wd, fd, ov);
        #1;
        mem_wr_valid = 0; dma_frame_done = 0; dma_overflow = 0;
        check("dma_start", {31'd0, dma_start}, {31'd0, m_start});
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("dma_buf_addr", dma_buf_addr, m_bufs[m_idx]);
        check("line_bytes", dma_line_bytes, m_line);
        check("num_lines", dma_num_lines, m_nl);
        mem_rd_addr = {24'($urandom), 8'($urandom_range(0, 15) * 4)};
        #1;
        check("rd_random", mem_rd_data, mread(mem_rd_addr));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d); cycle(1, a, d, 0, 0); endtask
    task automatic fd(); cycle(0, 8'h00, 0, 1, 0); endtask
    task automatic idle(); cycle(0, 8'h00, 0, 0, 0); endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        mem_rd_addr = {24'h0, a};
        #1;
        check(tag, mem_rd_data, exp);
    endtask

    task automatic do_reset();
        areset = 1;
        repeat (2) @(posedge aclk);
        #1 areset = 0;
        reset_model();
    endtask

    logic [31:0] t2_exp [5] = '{32'h2000, 32'h3000, 32'h4000, 32'h1000, 32'h2000};

    initial begin
        do_reset();
        rdchk("t1_version", 8'h00, 32'h0001_0000);
        rdchk("t1_ctrl", 8'h04, 32'h0);
        rdchk("t1_cnt", 8'h14, 32'h0);
        check("t1_irq", {31'd0, irq}, 32'd0);
        check("t1_start", {31'd0, dma_start}, 32'd0);

        wr(8'h20, 32'h1000); wr(8'h24, 32'h2000); wr(8'h28, 32'h3000); wr(8'h2C, 32'h4000);
        wr(8'h04, 32'h7); wr(8'h08, 32'h1);
        check("t2_start", {31'd0, dma_start}, 32'd1);
        check("t2_addr0", dma_buf_addr, 32'h1000);
        for (int k = 0; k < 5; k++) begin
            fd();
            check("t2_restart", {31'd0, dma_start}, 32'd1);
            check("t2_addr", dma_buf_addr, t2_exp[k]);
        end
        rdchk("t2_cnt", 8'h14, 32'd5);

        wr(8'h04, 32'h5); wr(8'h10, 32'h3); wr(8'h08, 32'h1);
        check("t3_start_in_run", {31'd0, dma_start}, 32'd0);
        fd();
        check("t3_no_restart", {31'd0, dma_start}, 32'd0);
        check("t3_irq_lag", {31'd0, irq}, 32'd0);
        rdchk("t3_status", 8'h0C, 32'h20);
        rdchk("t3_irq_sts", 8'h10, 32'h1);
        idle();
        check("t3_irq", {31'd0, irq}, 32'd1);
        wr(8'h08, 32'h1);
        check("t3_single_start", {31'd0, dma_start}, 32'd1);
        fd();
        check("t3_single_stop", {31'd0, dma_start}, 32'd0);

        wr(8'h08, 32'h1);
        cycle(1, 8'h10, 32'h1, 1, 0);
        rdchk("t4_set_wins", 8'h10, 32'h1);
        wr(8'h10, 32'h1);
        rdchk("t4_cleared", 8'h10, 32'h0);
        idle();
        check("t4_irq_low", {31'd0, irq}, 32'd0);

        wr(8'h08, 32'h1);
        wr(8'h04, 32'h0);
        mem_rd_addr = 32'h0C; #1;
        check("t5_stop_state", {30'd0, mem_rd_data[2:1]}, 32'd2);
        fd();
        check("t5_no_start", {31'd0, dma_start}, 32'd0);
        mem_rd_addr = 32'h0C; #1;
        check("t5_idle_state", {30'd0, mem_rd_data[2:1]}, 32'd0);
        rdchk("t5_cnt", 8'h14, 32'd9);

        wr(8'h04, 32'h1); wr(8'h08, 32'h1);
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.frame_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        fd();
        rdchk("t6_wrap", 8'h14, 32'd0);
        wr(8'h30, 32'hDEAD);
        rdchk("t6_unmapped", 8'h30, 32'd0);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] addrs [14] = '{8'h04, 8'h08, 8'h10, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h00, 8'h14, 8'h0C, 8'h3C};
            logic wv = $urandom_range(0, 9) < 5;
            logic [7:0] a = addrs[$urandom_range(0, 13)];
            logic [31:0] d = $urandom;
            logic f = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
            if (wv && a == 8'h04) f = 1'b0;
            dma_busy = $urandom_range(0, 1) == 1;
            cycle(wv, a, d, f, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
